// File: rtl/divider_unit_if.sv
// Request/response bundle between the execute-stage control and the multi-cycle divider.
// The master drives the operation request; the slave (the divider) returns stall, done and result.
interface divider_unit_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  i_flush;
   logic                  i_start;
   logic [1:0]            i_op;
   logic [DATA_WIDTH-1:0] i_dividend;
   logic [DATA_WIDTH-1:0] i_divisor;
   logic                  o_busy;
   logic                  o_done;
   logic [DATA_WIDTH-1:0] o_result;

   modport master (
      output i_flush, i_start, i_op, i_dividend, i_divisor,
      input  o_busy, o_done, o_result
   );

   modport slave (
      input  i_flush, i_start, i_op, i_dividend, i_divisor,
      output o_busy, o_done, o_result
   );
endinterface

// File: rtl/divider_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on operand
// magnitudes, sign fix-up on the final step, divide-by-zero and signed overflow resolved in one cycle.
module divider_unit #(
   parameter int DATA_WIDTH = 64
) (
   input logic           i_clk,
   input logic           i_arst,
   divider_unit_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  is_rem_q, is_rem_d;
   logic                  quot_neg_q, quot_neg_d;
   logic                  rem_neg_q, rem_neg_d;
   logic [DATA_WIDTH-1:0] quot_q, quot_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;

   logic                  accept;
   logic                  signed_op;
   logic                  dividend_neg;
   logic                  divisor_neg;
   logic                  div_by_zero;
   logic                  overflow;
   logic [DATA_WIDTH-1:0] dividend_mag;
   logic [DATA_WIDTH-1:0] divisor_mag;

   logic [DATA_WIDTH:0]   rem_shift;
   logic [DATA_WIDTH:0]   rem_diff;
   logic                  quot_bit;
   logic [DATA_WIDTH-1:0] rem_next;
   logic [DATA_WIDTH-1:0] quot_next;
   logic [DATA_WIDTH-1:0] quot_final;
   logic [DATA_WIDTH-1:0] rem_final;
   logic [DATA_WIDTH-1:0] formatted;

   // Flush has priority over start, so a flushed request never raises busy.
   assign accept       = (state_q == ST_IDLE) && bus.i_start && !bus.i_flush;
   assign signed_op    = ~bus.i_op[0];
   assign dividend_neg = signed_op & bus.i_dividend[DATA_WIDTH-1];
   assign divisor_neg  = signed_op & bus.i_divisor[DATA_WIDTH-1];
   assign dividend_mag = dividend_neg ? -bus.i_dividend : bus.i_dividend;
   assign divisor_mag  = divisor_neg  ? -bus.i_divisor  : bus.i_divisor;
   assign div_by_zero  = (bus.i_divisor == '0);
   assign overflow     = signed_op && (bus.i_dividend == MOST_NEG) && (bus.i_divisor == '1);

   // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder
   // while the new quotient bit enters at the LSB.
   assign rem_shift  = {rem_q, quot_q[DATA_WIDTH-1]};
   assign rem_diff   = rem_shift - {1'b0, divisor_q};
   assign quot_bit   = ~rem_diff[DATA_WIDTH];
   assign rem_next   = quot_bit ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
   assign quot_next  = {quot_q[DATA_WIDTH-2:0], quot_bit};
   assign quot_final = quot_neg_q ? -quot_next : quot_next;
   assign rem_final  = rem_neg_q  ? -rem_next  : rem_next;
   assign formatted  = is_rem_q ? rem_final : quot_final;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      is_rem_d   = is_rem_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      divisor_d  = divisor_q;
      result_d   = result_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               is_rem_d   = bus.i_op[1];
               quot_neg_d = dividend_neg ^ divisor_neg;
               rem_neg_d  = dividend_neg;
               quot_d     = dividend_mag;
               rem_d      = '0;
               divisor_d  = divisor_mag;
               count_d    = '0;
               if (div_by_zero) begin
                  result_d = bus.i_op[1] ? bus.i_dividend : '1;
                  state_d  = ST_DONE;
               end else if (overflow) begin
                  result_d = bus.i_op[1] ? '0 : bus.i_dividend;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            quot_d  = quot_next;
            rem_d   = rem_next;
            count_d = count_q + 1'b1;
            if (count_q == LAST_ITER) begin
               result_d = formatted;
               count_d  = '0;
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A kill leaves the previously presented result untouched.
      if (bus.i_flush) begin
         state_d  = ST_IDLE;
         count_d  = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         is_rem_q   <= 1'b0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         is_rem_q   <= is_rem_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         divisor_q  <= divisor_d;
         result_q   <= result_d;
      end
   end

   assign bus.o_busy   = (state_q == ST_CALC) || accept;
   assign bus.o_done   = (state_q == ST_DONE);
   assign bus.o_result = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: the driver pushes reference-model results with their expected
// completion edge, and a monitor pops and compares whenever o_done is seen.
module tb_divider_unit;

   localparam int W = 64;

   typedef struct {
      logic [W-1:0] result;
      int           edge_no;
      string        name;
   } exp_t;

   logic clk;
   logic rst;
   int   edges;
   int   total;
   int   bad;
   exp_t sb[$];
   exp_t mon_e;
   logic [W-1:0] exp_result;

   divider_unit_if #(.DATA_WIDTH(W)) bus ();

   divider_unit #(.DATA_WIDTH(W)) dut (
      .i_clk  (clk),
      .i_arst (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: the architectural rules written directly as integer arithmetic.
   function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic is_rem;
      logic sgn;
      is_rem = op[1];
      sgn    = !op[0];
      if (b == '0) return is_rem ? a : '1;
      if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) return is_rem ? '0 : a;
      if (sgn) return is_rem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
      return is_rem ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == '0) || (!op[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1);
   endfunction

   // Monitor: sampled 2 time units after each rising edge, away from both clock edges.
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         if (bus.o_done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_done: got done=1 result=%h expected no completion", bus.o_result);
            end else begin
               mon_e = sb.pop_front();
               check_output({mon_e.name, " result"}, bus.o_result, mon_e.result);
               check_output({mon_e.name, " done_edge"}, W'(edges), W'(mon_e.edge_no));
               exp_result = mon_e.result;
            end
         end else begin
            check_output("result_hold", bus.o_result, exp_result);
         end
      end
   end

   // Called at a falling edge with the DUT idle; the request is held for exactly one cycle.
   task automatic apply_stimulus(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      bus.i_start    = 1'b1;
      bus.i_op       = op;
      bus.i_dividend = a;
      bus.i_divisor  = b;
      #1;
      check_output({name, " busy_at_start"}, W'(bus.o_busy), W'(1));
      e.result  = ref_model(op, a, b);
      e.edge_no = edges + 1 + (is_special(op, a, b) ? 0 : W);
      e.name    = name;
      sb.push_back(e);
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   // Leaves the bench at a falling edge with the DUT back in idle.
   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 4 * W) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.i_start   = 1'b0;
      bus.i_flush   = 1'b0;
      @(negedge clk);
      check_output("reset done", W'(bus.o_done), W'(0));
      check_output("reset result", bus.o_result, '0);
      check_output("reset busy", W'(bus.o_busy), W'(0));
      sb.delete();
      exp_result = '0;
      rst        = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      longint       sa;
      longint       sb_val;
      int           mode;

      total          = 0;
      bad            = 0;
      edges          = 0;
      exp_result     = '0;
      rst            = 1'b1;
      bus.i_flush    = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_op       = 2'b00;
      bus.i_dividend = '0;
      bus.i_divisor  = '0;

      do_reset();

      // Unsigned divide with the stall window watched cycle by cycle.
      apply_stimulus("divu_100_7", 2'b01, W'(100), W'(7));
      for (int k = 1; k <= W; k++) begin
         check_output("divu_100_7 busy_calc", W'(bus.o_busy), W'(1));
         @(negedge clk);
      end
      check_output("divu_100_7 busy_done", W'(bus.o_busy), W'(0));
      check_output("divu_100_7 done_pulse", W'(bus.o_done), W'(1));
      wait_drain();

      apply_stimulus("remu_100_7", 2'b11, W'(100), W'(7));
      wait_drain();

      apply_stimulus("div_m7_2", 2'b00, -W'(7), W'(2));
      wait_drain();
      apply_stimulus("rem_m7_2", 2'b10, -W'(7), W'(2));
      wait_drain();
      apply_stimulus("div_7_m2", 2'b00, W'(7), -W'(2));
      wait_drain();
      apply_stimulus("rem_7_m2", 2'b10, W'(7), -W'(2));
      wait_drain();
      apply_stimulus("rem_m6_3", 2'b10, -W'(6), W'(3));
      wait_drain();

      // Single-cycle special cases.
      apply_stimulus("divu_5_0", 2'b01, W'(5), '0);
      wait_drain();
      apply_stimulus("remu_5_0", 2'b11, W'(5), '0);
      wait_drain();
      apply_stimulus("rem_m5_0", 2'b10, -W'(5), '0);
      wait_drain();
      apply_stimulus("div_ovf", 2'b00, {1'b1, {(W-1){1'b0}}}, '1);
      wait_drain();
      apply_stimulus("rem_ovf", 2'b10, {1'b1, {(W-1){1'b0}}}, '1);
      wait_drain();
      apply_stimulus("divu_min_ones", 2'b01, {1'b1, {(W-1){1'b0}}}, '1);
      wait_drain();

      // Kill mid-calculation, then restart in the very next cycle.
      apply_stimulus("flush_victim", 2'b01, W'(100), W'(7));
      repeat (8) @(negedge clk);
      @(negedge clk);
      bus.i_flush = 1'b1;
      #1;
      check_output("flush busy_during", W'(bus.o_busy), W'(1));
      @(negedge clk);
      bus.i_flush = 1'b0;
      sb.delete();
      #1;
      check_output("flush busy_after", W'(bus.o_busy), W'(0));
      apply_stimulus("divu_9_3_after_flush", 2'b01, W'(9), W'(3));
      wait_drain();

      // Start pulses while calculating must not disturb the op in flight.
      apply_stimulus("divu_ignore_restart", 2'b01, W'(1000), W'(10));
      repeat (5) @(negedge clk);
      bus.i_start    = 1'b1;
      bus.i_op       = 2'b11;
      bus.i_dividend = W'(7);
      bus.i_divisor  = W'(3);
      @(negedge clk);
      bus.i_start    = 1'b0;
      repeat (20) @(negedge clk);
      bus.i_start    = 1'b1;
      bus.i_op       = 2'b00;
      bus.i_dividend = -W'(50);
      @(negedge clk);
      bus.i_start    = 1'b0;
      wait_drain();

      // Start and flush together in idle: nothing accepted.
      bus.i_start    = 1'b1;
      bus.i_flush    = 1'b1;
      bus.i_op       = 2'b01;
      bus.i_dividend = W'(50);
      bus.i_divisor  = W'(5);
      #1;
      check_output("start_flush busy", W'(bus.o_busy), W'(0));
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_flush = 1'b0;
      repeat (W + 4) @(negedge clk);
      check_output("start_flush idle_busy", W'(bus.o_busy), W'(0));

      // Reset in the middle of a calculation.
      apply_stimulus("reset_victim", 2'b01, W'(12345), W'(11));
      repeat (18) @(negedge clk);
      do_reset();
      repeat (W + 4) @(negedge clk);

      for (int i = 0; i < 36; i++) begin
         op   = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 5);
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         case (mode)
            1: begin
               a = W'($urandom_range(0, 100000));
               b = W'($urandom_range(1, 300));
            end
            2: b = '0;
            3: begin
               a = {1'b1, {(W-1){1'b0}}};
               b = '1;
            end
            4: begin
               sa     = longint'($urandom_range(0, 2000)) - 1000;
               sb_val = longint'($urandom_range(0, 40)) - 20;
               a      = W'(sa);
               b      = W'(sb_val);
            end
            5: b = W'($urandom_range(1, 1 << 20));
            default: ;
         endcase
         apply_stimulus("rand", op, a, b);
         wait_drain();
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
